// File: rtl/rx_pkg.sv
// Shared constants and helpers for the RX I/Q packing path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rx_pkg;

    localparam int IQ_W   = 24;
    localparam int WORD_W = 2 * IQ_W;
    localparam int MAX_RX = 8;

    // One FIFO word: I in the upper half so the byte mux emits I MSBs first.
    function automatic logic [WORD_W-1:0] pack_iq(input logic [IQ_W-1:0] i,
                                                  input logic [IQ_W-1:0] q);
        return {i, q};
    endfunction

    // Number of set bits in a per-channel event vector.
    function automatic logic [3:0] popcount(input logic [MAX_RX-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < MAX_RX; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

    // a + b clipped to maxv; the 33-bit sum cannot wrap.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] maxv);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, maxv}) begin
            return maxv;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/rx_iq_hold.sv
// Per-channel hold register: captures one I/Q pair, tracks pending and overrun.
// Latency: strobe at edge t -> word/pending visible from cycle t+1.
// Backpressure: none; a new strobe over an unwritten word overwrites it and flags overrun.
module rx_iq_hold #(
    parameter int IQ_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              strobe_i,
    input  logic [IQ_W-1:0]   i_i,
    input  logic [IQ_W-1:0]   q_i,
    input  logic              wr_i,
    input  logic              drop_i,
    input  logic              clr_i,
    output logic [2*IQ_W-1:0] word_o,
    output logic              pend_o,
    output logic              ovf_o,
    output logic              ovr_o
);

    logic [2*IQ_W-1:0] word_q, word_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;

    // A strobe landing on the very cycle this word is written is not a loss.
    assign ovr_o  = strobe_i & pend_q & ~wr_i;
    assign word_o = word_q;
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

    // Next state: capture wins over write/drop, disable discards pending, clear beats set.
    always_comb begin
        word_d = word_q;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (strobe_i) begin
            word_d = {i_i, q_i};
        end
        if (wr_i || drop_i) begin
            pend_d = 1'b0;
        end
        if (strobe_i) begin
            pend_d = 1'b1;
        end
        if (!enable_i) begin
            pend_d = 1'b0;
        end
        if (clr_i) begin
            ovf_d = 1'b0;
        end else if (ovr_o) begin
            ovf_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/rx_iq_packer.sv
// Packs per-receiver I/Q pairs into {I,Q} words and writes them in strict RX0..RXn order.
// Latency: one cycle from strobe to fifo_wrreq at the earliest.
// Backpressure: fifo_full freezes the channel pointer; samples arriving meanwhile overwrite and count as overruns.
module rx_iq_packer #(
    parameter int NUM_RX = 4,
    parameter int IQ_W   = 24,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             num_active,
    input  logic                   enable,
    input  logic [NUM_RX-1:0]      rx_strobe,
    input  logic [NUM_RX*IQ_W-1:0] rx_i,
    input  logic [NUM_RX*IQ_W-1:0] rx_q,
    input  logic                   fifo_full,
    output logic                   fifo_wrreq,
    output logic [2*IQ_W-1:0]      fifo_data,
    output logic [NUM_RX-1:0]      overrun,
    output logic [CNT_W-1:0]       overrun_cnt,
    input  logic                   overrun_clr
);

    import rx_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]        ch_q, ch_d;
    logic [2:0]        act_q, act_d;
    logic [2:0]        act_new;
    logic              boundary;
    logic [NUM_RX-1:0] wr_vec;
    logic [NUM_RX-1:0] drop_vec;
    logic [MAX_RX-1:0] pend_x;
    logic [MAX_RX-1:0] ovr_x;
    logic [2*IQ_W-1:0] word_x [MAX_RX];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Padded to MAX_RX so the 3-bit pointer always indexes a defined slot.
    for (genvar k = 0; k < MAX_RX; k++) begin : g_ch
        if (k < NUM_RX) begin : g_hold
            rx_iq_hold #(.IQ_W(IQ_W)) u_hold (
                .clk      (clk),
                .reset    (reset),
                .enable_i (enable),
                .strobe_i (rx_strobe[k]),
                .i_i      (rx_i[k*IQ_W +: IQ_W]),
                .q_i      (rx_q[k*IQ_W +: IQ_W]),
                .wr_i     (wr_vec[k]),
                .drop_i   (drop_vec[k]),
                .clr_i    (overrun_clr),
                .word_o   (word_x[k]),
                .pend_o   (pend_x[k]),
                .ovf_o    (overrun[k]),
                .ovr_o    (ovr_x[k])
            );
        end else begin : g_pad
            assign word_x[k] = '0;
            assign pend_x[k] = 1'b0;
            assign ovr_x[k]  = 1'b0;
        end
    end

    // Only the pointed-at channel may write; ready channels behind it wait their turn.
    assign fifo_wrreq = enable & pend_x[ch_q] & ~fifo_full;
    assign fifo_data  = word_x[ch_q];
    assign act_new    = (int'(num_active) >= NUM_RX) ? 3'(NUM_RX - 1) : num_active;
    assign boundary   = (ch_q == 3'd0) & ~fifo_wrreq;

    // Pointer, frame-size latch, per-channel write/drop strobes and counter next state.
    always_comb begin
        wr_vec   = '0;
        drop_vec = '0;
        ch_d     = ch_q;
        act_d    = act_q;
        for (int k = 0; k < NUM_RX; k++) begin
            wr_vec[k]   = fifo_wrreq & (ch_q == 3'(k));
            drop_vec[k] = boundary & (act_new != act_q) & (3'(k) > act_new);
        end
        if (!enable) begin
            ch_d = 3'd0;
        end else if (fifo_wrreq) begin
            ch_d = (ch_q == act_q) ? 3'd0 : ch_q + 3'd1;
        end
        if (boundary) begin
            act_d = act_new;
        end
        if (overrun_clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = CNT_W'(sat_add(32'(cnt_q), 32'(popcount(ovr_x)), 32'(CNT_MAX)));
        end
    end

    // Pointer, latched frame size and overrun counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q  <= 3'd0;
            act_q <= 3'd0;
            cnt_q <= '0;
        end else begin
            ch_q  <= ch_d;
            act_q <= act_d;
            cnt_q <= cnt_d;
        end
    end

    assign overrun_cnt = cnt_q;

endmodule

// File: tb/tb_rx_iq_packer.sv
// Self-checking bench for rx_iq_packer: directed scenarios plus a randomized run
// against a behavioural model of the packing rules.
module tb_rx_iq_packer;
    import rx_pkg::*;

    localparam int NRX = 4;
    localparam int W   = 24;
    localparam int CW  = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       num_active = 3'd3;
    logic             enable = 1'b1;
    logic [NRX-1:0]   rx_strobe = '0;
    logic [NRX*W-1:0] rx_i = '0;
    logic [NRX*W-1:0] rx_q = '0;
    logic             fifo_full = 1'b0;
    logic             fifo_wrreq;
    logic [2*W-1:0]   fifo_data;
    logic [NRX-1:0]   overrun;
    logic [CW-1:0]    overrun_cnt;
    logic             overrun_clr = 1'b0;

    always #5 clk = ~clk;

    rx_iq_packer #(.NUM_RX(NRX), .IQ_W(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .num_active  (num_active),
        .enable      (enable),
        .rx_strobe   (rx_strobe),
        .rx_i        (rx_i),
        .rx_q        (rx_q),
        .fifo_full   (fifo_full),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_data   (fifo_data),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .overrun_clr (overrun_clr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: one slot per receiver, a round-robin turn, a frame size.
    logic [2*W-1:0] m_val [NRX];
    bit             m_pend [NRX];
    int             m_ptr = 0;
    int             m_act = 0;
    int             m_cnt = 0;
    logic [NRX-1:0] m_ovf = '0;

    int             got_cyc [$];
    int             exp_cyc [$];
    logic [2*W-1:0] got_dat [$];
    logic [2*W-1:0] exp_dat [$];

    task automatic model_update(input bit wr);
        int new_act;
        int n;
        bit bnd;
        if (reset) begin
            for (int k = 0; k < NRX; k++) begin
                m_val[k]  = '0;
                m_pend[k] = 0;
            end
            m_ptr = 0; m_act = 0; m_cnt = 0; m_ovf = '0;
            return;
        end
        new_act = (int'(num_active) >= NRX) ? NRX - 1 : int'(num_active);
        n = 0;
        for (int k = 0; k < NRX; k++) begin
            if (rx_strobe[k] && m_pend[k] && !(wr && m_ptr == k)) begin
                n++;
                m_ovf[k] = 1'b1;
            end
        end
        if (overrun_clr) begin
            m_ovf = '0;
            m_cnt = 0;
        end else begin
            m_cnt = (m_cnt + n > CMAX) ? CMAX : m_cnt + n;
        end
        bnd = (m_ptr == 0) && !wr;
        for (int k = 0; k < NRX; k++) begin
            if (wr && m_ptr == k) m_pend[k] = 0;
            if (bnd && new_act != m_act && k > new_act) m_pend[k] = 0;
            if (rx_strobe[k]) begin
                m_pend[k] = 1;
                m_val[k]  = pack_iq(rx_i[k*W +: W], rx_q[k*W +: W]);
            end
            if (!enable) m_pend[k] = 0;
        end
        if (!enable) m_ptr = 0;
        else if (wr) m_ptr = (m_ptr == m_act) ? 0 : m_ptr + 1;
        if (bnd) m_act = new_act;
    endtask

    // One clock: log observed and predicted writes mid-cycle, advance the model at the edge.
    task automatic tick();
        bit             ewr;
        logic [2*W-1:0] ew;
        @(negedge clk);
        ewr = enable && m_pend[m_ptr] && !fifo_full;
        ew  = m_val[m_ptr];
        if (fifo_wrreq === 1'b1) begin
            got_cyc.push_back(cyc);
            got_dat.push_back(fifo_data);
        end
        if (ewr) begin
            exp_cyc.push_back(cyc);
            exp_dat.push_back(ew);
        end
        @(posedge clk);
        model_update(ewr);
        cyc++;
        #1;
        rx_strobe   = '0;
        overrun_clr = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] iv, input logic [W-1:0] qv);
        rx_strobe[k]    = 1'b1;
        rx_i[k*W +: W]  = iv;
        rx_q[k*W +: W]  = qv;
    endtask

    task automatic clear_logs();
        got_cyc.delete(); got_dat.delete();
        exp_cyc.delete(); exp_dat.delete();
    endtask

    task automatic do_reset();
        enable = 1'b1; fifo_full = 1'b0; num_active = 3'd3;
        reset = 1'b1;
        tick();
        tick();
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("FAIL reset_wrreq: got %b want 0", fifo_wrreq); end
        total++; if (fifo_data !== 48'h0) begin bad++; $display("FAIL reset_data: got %h want 0", fifo_data); end
        total++; if (overrun !== 4'h0) begin bad++; $display("FAIL reset_overrun: got %b want 0000", overrun); end
        total++; if (overrun_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", overrun_cnt); end
        tick();
        set_ch(0, 24'hABCDEF, 24'h123456);
        tick();
        total++; if (fifo_wrreq !== 1'b1) begin bad++; $display("FAIL min_latency_wrreq: got %b want 1", fifo_wrreq); end
        total++; if (fifo_data !== 48'hABCDEF_123456) begin bad++; $display("FAIL min_latency_data: got %h want abcdef123456", fifo_data); end
    endtask

    task automatic test_all_channels();
        logic [2*W-1:0] want [4];
        int c;
        want[0] = 48'h000001_000010; want[1] = 48'h000002_000011;
        want[2] = 48'h000003_000012; want[3] = 48'h000004_000013;
        do_reset();
        c = cyc;
        for (int k = 0; k < 4; k++) set_ch(k, 24'(k + 1), 24'(k + 16));
        repeat (8) tick();
        total++; if (got_dat.size() !== 4) begin bad++; $display("FAIL all_ch_count: got %0d want 4", got_dat.size()); end
        for (int n = 0; n < 4 && n < got_dat.size(); n++) begin
            total++;
            if (got_dat[n] !== want[n] || got_cyc[n] !== c + 1 + n) begin
                bad++; $display("FAIL all_ch_word%0d: got %h@%0d want %h@%0d", n, got_dat[n], got_cyc[n], want[n], c + 1 + n);
            end
        end
        total++; if (got_dat != exp_dat || got_cyc != exp_cyc) begin bad++; $display("FAIL all_ch_model: got %0d writes want %0d", got_dat.size(), exp_dat.size()); end
    endtask

    task automatic test_ordering();
        int cb, cc;
        do_reset();
        set_ch(2, 24'h0002A2, 24'h0002B2);
        tick();
        repeat (4) tick();
        cb = cyc;
        set_ch(0, 24'h0000A0, 24'h0000B0);
        tick();
        repeat (3) tick();
        cc = cyc;
        set_ch(1, 24'h0001A1, 24'h0001B1);
        tick();
        repeat (4) tick();
        total++; if (got_dat.size() !== 3) begin bad++; $display("FAIL order_count: got %0d want 3", got_dat.size()); end
        if (got_dat.size() == 3) begin
            total++; if (got_dat[0] !== 48'h0000A0_0000B0 || got_cyc[0] !== cb + 1) begin bad++; $display("FAIL order_rx0: got %h@%0d want 0000a00000b0@%0d", got_dat[0], got_cyc[0], cb + 1); end
            total++; if (got_dat[1] !== 48'h0001A1_0001B1 || got_cyc[1] !== cc + 1) begin bad++; $display("FAIL order_rx1: got %h@%0d want 0001a10001b1@%0d", got_dat[1], got_cyc[1], cc + 1); end
            total++; if (got_dat[2] !== 48'h0002A2_0002B2 || got_cyc[2] !== cc + 2) begin bad++; $display("FAIL order_rx2: got %h@%0d want 0002a20002b2@%0d", got_dat[2], got_cyc[2], cc + 2); end
        end
    endtask

    task automatic test_full_overrun();
        do_reset();
        fifo_full = 1'b1;
        set_ch(0, 24'h111111, 24'h000001); tick();
        set_ch(0, 24'h222222, 24'h000002); tick();
        set_ch(0, 24'h333333, 24'h000003); tick();
        repeat (3) tick();
        total++; if (got_dat.size() !== 0) begin bad++; $display("FAIL full_no_write: got %0d writes want 0", got_dat.size()); end
        fifo_full = 1'b0;
        repeat (3) tick();
        total++; if (got_dat.size() !== 1) begin bad++; $display("FAIL full_one_write: got %0d want 1", got_dat.size()); end
        if (got_dat.size() > 0) begin
            total++; if (got_dat[0] !== 48'h333333_000003) begin bad++; $display("FAIL full_last_sample: got %h want 333333000003", got_dat[0]); end
        end
        total++; if (overrun !== 4'b0001) begin bad++; $display("FAIL full_overrun: got %b want 0001", overrun); end
        total++; if (overrun_cnt !== 16'd2) begin bad++; $display("FAIL full_cnt: got %0d want 2", overrun_cnt); end
    endtask

    task automatic test_strobe_on_write();
        int c;
        logic [2*W-1:0] want [6];
        do_reset();
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            set_ch(k, 24'(256 + k), 24'(512 + k));
            want[k] = pack_iq(24'(256 + k), 24'(512 + k));
        end
        want[4] = 48'hB0B0B0_0B0B0B;
        want[5] = 48'hB1B1B1_1B1B1B;
        tick();
        tick();
        set_ch(1, 24'hB1B1B1, 24'h1B1B1B);
        tick();
        repeat (3) tick();
        set_ch(0, 24'hB0B0B0, 24'h0B0B0B);
        tick();
        repeat (4) tick();
        total++; if (got_dat.size() !== 6) begin bad++; $display("FAIL sow_count: got %0d want 6", got_dat.size()); end
        for (int n = 0; n < 6 && n < got_dat.size(); n++) begin
            total++; if (got_dat[n] !== want[n]) begin bad++; $display("FAIL sow_word%0d: got %h want %h", n, got_dat[n], want[n]); end
        end
        if (got_cyc.size() > 1) begin
            total++; if (got_cyc[1] !== c + 2) begin bad++; $display("FAIL sow_coincide: got cycle %0d want %0d", got_cyc[1], c + 2); end
        end
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL sow_cnt: got %0d want 0", overrun_cnt); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL sow_overrun: got %b want 0000", overrun); end
    endtask

    task automatic test_active_change();
        logic [2*W-1:0] want [8];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_ch(k, 24'(k + 32'h0A0), 24'(k + 32'h0A8));
            want[k] = pack_iq(24'(k + 32'h0A0), 24'(k + 32'h0A8));
        end
        tick();
        tick();
        tick();
        num_active = 3'd1;
        repeat (4) tick();
        for (int k = 0; k < 4; k++) set_ch(k, 24'(k + 32'h0B0), 24'(k + 32'h0B8));
        want[4] = pack_iq(24'h0B0, 24'h0B8);
        want[5] = pack_iq(24'h0B1, 24'h0B9);
        tick();
        repeat (4) tick();
        for (int k = 0; k < 4; k++) set_ch(k, 24'(k + 32'h0C0), 24'(k + 32'h0C8));
        want[6] = pack_iq(24'h0C0, 24'h0C8);
        want[7] = pack_iq(24'h0C1, 24'h0C9);
        tick();
        repeat (4) tick();
        total++; if (got_dat.size() !== 8) begin bad++; $display("FAIL act_count: got %0d want 8", got_dat.size()); end
        for (int n = 0; n < 8 && n < got_dat.size(); n++) begin
            total++; if (got_dat[n] !== want[n]) begin bad++; $display("FAIL act_word%0d: got %h want %h", n, got_dat[n], want[n]); end
        end
        total++; if (overrun_cnt !== 16'd2) begin bad++; $display("FAIL act_cnt: got %0d want 2", overrun_cnt); end
        total++; if (overrun !== 4'b1100) begin bad++; $display("FAIL act_overrun: got %b want 1100", overrun); end
        num_active = 3'd3;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        set_ch(3, 24'h3, 24'h3); tick();
        set_ch(3, 24'h4, 24'h4); tick();
        for (int k = 0; k < 4; k++) set_ch(k, 24'(k), 24'(k));
        tick();
        tick();
        total++; if (overrun_cnt !== 16'd2) begin bad++; $display("FAIL rmf_precnt: got %0d want 2", overrun_cnt); end
        reset = 1'b1;
        tick();
        total++; if (fifo_wrreq !== 1'b0) begin bad++; $display("FAIL rmf_wrreq: got %b want 0", fifo_wrreq); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL rmf_overrun: got %b want 0000", overrun); end
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL rmf_cnt: got %0d want 0", overrun_cnt); end
        total++; if (fifo_data !== 48'h0) begin bad++; $display("FAIL rmf_data: got %h want 0", fifo_data); end
        clear_logs();
        set_ch(1, 24'hE1E1E1, 24'h1E1E1E); tick();
        repeat (2) tick();
        set_ch(0, 24'hE0E0E0, 24'h0E0E0E); tick();
        repeat (3) tick();
        total++; if (got_dat.size() !== 2) begin bad++; $display("FAIL rmf_count: got %0d want 2", got_dat.size()); end
        if (got_dat.size() == 2) begin
            total++; if (got_dat[0] !== 48'hE0E0E0_0E0E0E) begin bad++; $display("FAIL rmf_first_rx0: got %h want e0e0e00e0e0e", got_dat[0]); end
            total++; if (got_dat[1] !== 48'hE1E1E1_1E1E1E) begin bad++; $display("FAIL rmf_second_rx1: got %h want e1e1e11e1e1e", got_dat[1]); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        fifo_full = 1'b1;
        for (int t = 0; t < 16400; t++) begin
            for (int k = 0; k < 4; k++) set_ch(k, 24'($urandom), 24'($urandom));
            tick();
            if (t == 1) begin
                total++; if (overrun_cnt !== 16'd4) begin bad++; $display("FAIL sat_popcount: got %0d want 4", overrun_cnt); end
            end
        end
        total++; if (overrun_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_max: got %h want ffff", overrun_cnt); end
        total++; if (overrun !== 4'b1111) begin bad++; $display("FAIL sat_flags: got %b want 1111", overrun); end
        for (int k = 0; k < 4; k++) set_ch(k, 24'($urandom), 24'($urandom));
        overrun_clr = 1'b1;
        tick();
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL clr_priority_cnt: got %0d want 0", overrun_cnt); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL clr_priority_flags: got %b want 0000", overrun); end
        fifo_full = 1'b0;
    endtask

    task automatic test_random();
        int en_hold;
        en_hold = 0;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if (t % 97 == 50) num_active = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) en_hold = $urandom_range(2, 6);
            enable = (en_hold == 0);
            if (en_hold > 0) en_hold--;
            fifo_full   = ($urandom_range(0, 3) == 0);
            overrun_clr = ($urandom_range(0, 49) == 0);
            if (enable) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 99) < 35) set_ch(k, 24'($urandom), 24'($urandom));
                end
            end
            tick();
            total++; if (overrun !== m_ovf) begin bad++; $display("FAIL rnd_overrun@%0d: got %b want %b", cyc, overrun, m_ovf); end
            total++; if (overrun_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cyc, overrun_cnt, m_cnt); end
        end
        enable = 1'b1; fifo_full = 1'b0; num_active = 3'd3;
        total++; if (got_dat.size() !== exp_dat.size()) begin bad++; $display("FAIL rnd_write_count: got %0d want %0d", got_dat.size(), exp_dat.size()); end
        for (int n = 0; n < got_dat.size() && n < exp_dat.size(); n++) begin
            total++;
            if (got_dat[n] !== exp_dat[n] || got_cyc[n] !== exp_cyc[n]) begin
                bad++; $display("FAIL rnd_write%0d: got %h@%0d want %h@%0d", n, got_dat[n], got_cyc[n], exp_dat[n], exp_cyc[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_channels();
        test_ordering();
        test_full_overrun();
        test_strobe_on_write();
        test_active_change();
        test_reset_mid_frame();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_iq_packer.md
Name: rx_iq_packer

Overview:
- Upstream stage of the RX output path, in the DDC clock domain.
- Collects 24-bit I/Q samples from NUM_RX receivers and packs each pair into one 48-bit word {I,Q}.
- Writes the words, in strict receiver order, into the dual-clock sample FIFO. The DDR byte mux on the Pi side drains that FIFO 16 bits per clock, I MSBs first.
- Detects and counts per-channel overruns so software can flag lost samples.

Parameters:
- NUM_RX, 4, number of receiver channels (1..8).
- IQ_W, 24, width of each I and Q sample.
- CNT_W, 16, width of the overrun counter.

Ports:
- clk  in  1  DDC clock.
- reset  in  1  synchronous, active-high.
- num_active  in  3  active receivers minus 1 (0 = RX0 only); values ≥ NUM_RX clamp to NUM_RX-1.
- enable  in  1  high = packing active.
- rx_strobe  in  NUM_RX  one-cycle sample-valid pulse per receiver.
- rx_i  in  NUM_RX*IQ_W  I samples; channel k at [k*IQ_W +: IQ_W].
- rx_q  in  NUM_RX*IQ_W  Q samples, same layout.
- fifo_full  in  1  FIFO full flag (write side).
- fifo_wrreq  out  1  FIFO write strobe.
- fifo_data  out  2*IQ_W  {I[23:0], Q[23:0]}.
- overrun  out  NUM_RX  sticky per-channel overrun flags.
- overrun_cnt  out  CNT_W  total overruns, saturating.
- overrun_clr  in  1  clears overrun and overrun_cnt.

Behaviour:
- Reset values:
  - hold registers, pending, overrun, overrun_cnt = 0
  - channel pointer ch = 0
  - active_n latched = 0
  - fifo_wrreq = 0 (combinational, forced low by pending = 0)
  - fifo_data = 0
- Capture: on rx_strobe[k] at edge t, hold_i/q[k] <= rx_i/q[k] and pending[k] <= 1. Both are visible from cycle t+1.
- Write rule:
  - fifo_wrreq = enable & pending[ch] & !fifo_full, combinational from registers and fifo_full.
  - fifo_data = hold[ch]. It is driven from the hold registers, so it is stable whenever wrreq is high.
  - Minimum latency from strobe to wrreq is one cycle.
- On each cycle where wrreq = 1:
  - pending[ch] clears.
  - ch advances: ch <= (ch == active_n) ? 0 : ch+1.
- Ordering: ch waits on its own channel only. Words always leave as RX0, RX1, ..., RXactive_n, RX0, ... The Pi relies on this interleave. Later channels that are ready never bypass ch.
- num_active is sampled into active_n only when ch == 0 and no write is occurring, i.e. at a frame boundary. A change mid-frame therefore takes effect at the next frame.
- Channels above active_n:
  - Still capture and set pending; pending never clears.
  - Their overruns are counted.
  - On the active_n change, pending for channels above the new active_n clears.
- Overrun: rx_strobe[k] while pending[k] = 1 and channel k is not being written in the same cycle.
  - The new sample overwrites the hold register (freshest data wins).
  - overrun[k] <= 1.
  - overrun_cnt increments, saturating at all-ones.
  - Multiple simultaneous overruns add their popcount in one cycle, saturating.
- Simultaneous strobe and write on the same channel: the old word is written, the new sample is captured, pending stays 1, and no overrun is recorded.
- fifo_full held high: no writes and ch is frozen. Overruns accumulate per the rule above. Writing resumes in the first cycle full is low.
- enable = 0: no writes, and ch resets to 0 on the next edge. Pending is discarded, so the frame restarts cleanly when enable returns. Capture continues.
- overrun_clr has priority over increments in the same cycle.
- Reset mid-frame: everything returns to reset values on the next edge. No partial frame survives.

Decomposition:
- Package rx_pkg holds:
  - IQ_W, WORD_W = 2*IQ_W, MAX_RX = 8
  - function pack_iq(i,q) returning {i,q}
  - popcount/saturating-add helper
- One sub-module, rx_iq_hold: a per-channel hold register with pending/overrun logic, instantiated NUM_RX times via generate. The pointer, arbiter and counter live in the top level.

Test Plan:
1. NUM_RX=4, num_active=3, full=0; strobe RX0..RX3 in one cycle with I=k+1, Q=k+0x10 → four consecutive wrreq cycles with fifo_data 0x000001_000010, 0x000002_000011, 0x000003_000012, 0x000004_000013, in that order.
2. Strobe RX2 only, then RX0 five cycles later → no write until the RX0 word is written; RX2 is written after RX1 arrives, never before it.
3. Hold full=1 and strobe RX0 three times → one write after full drops, holding the last sample; overrun[0]=1; overrun_cnt=2.
4. Strobe RX1 in the exact cycle its pending word is written → word written, new sample written next round, overrun_cnt unchanged.
5. Change num_active 3→1 while ch=2 → frame completes through RX3, then output alternates RX0, RX1 only.
6. Assert reset mid-frame with pending bits set → next cycle wrreq=0, overrun=0, overrun_cnt=0, and the first write after reset comes from RX0.
